// File: rtl/divider_signed_param.sv
// rtl/divider_signed_param.sv - Sequential radix-2 restoring divider with signed/unsigned mode select
module divider_signed_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             not_valid,
    output logic             idle,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic             ovf;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // In WIDTH bits, negating the most-negative value yields 2^(WIDTH-1) read as unsigned
    assign dvd_abs   = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_abs   = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign shifted   = {rem, quo[WIDTH-1]};
    assign no_borrow = (shifted >= dvs_mag);
    assign q_fix     = neg_q ? -quo : quo;
    assign r_fix     = neg_r ? -rem : rem;
    assign idle      = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs_mag   <= '0;
            dvd_raw   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            not_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (strt) begin
                        quo     <= dvd_abs;
                        rem     <= '0;
                        dvs_mag <= {1'b0, dvs_abs};
                        dvd_raw <= dividend;
                        neg_r   <= sgn & dividend[WIDTH-1];
                        neg_q   <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        div0    <= (divisor == '0);
                        ovf     <= sgn && (dividend == MOST_NEG) && (divisor == '1);
                        if (divisor == '0) begin
                            cnt   <= '0;
                            state <= S_FIX;
                        end else begin
                            cnt   <= CW'(WIDTH);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= no_borrow ? WIDTH'(shifted - dvs_mag) : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], no_borrow};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (div0) begin
                        quotient  <= '1;
                        remainder <= dvd_raw;
                        not_valid <= 1'b1;
                    end else begin
                        // most-negative / -1 naturally yields {MOST_NEG, 0}; only the flag differs
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        not_valid <= ovf;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
